// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and port-packing helper for regfile_mp
package regfile_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int ZERO_REG   = 0;

   // Low bit of port 'port' inside a bus where every port is 'w' bits wide
   function automatic int field_lo(input int port, input int w);
      return port * w;
   endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - register file port bundle (write, read, busy marking)
interface regfile_mp_if
   import regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2
);

   logic [NUM_WR-1:0]        wr_en;
   logic [NUM_WR*ADDR_W-1:0] wr_addr;
   logic [NUM_WR*DATA_W-1:0] wr_data;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     mark_en;
   logic [ADDR_W-1:0]        mark_addr;

   modport master (
      output wr_en, wr_addr, wr_data, rd_addr, mark_en, mark_addr,
      input  rd_data, rd_busy
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addr, mark_en, mark_addr,
      output rd_data, rd_busy
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits; optional macro REGFILE_BYPASS_EN forwards post-edge busy
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int NUM_CLR = 2,
   parameter int NUM_LK  = 2
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_CLR-1:0]        clr_en,
   input  logic [NUM_CLR*ADDR_W-1:0] clr_addr,
   input  logic                      mark_en,
   input  logic [ADDR_W-1:0]         mark_addr,
   input  logic [NUM_LK*ADDR_W-1:0]  lk_addr,
   output logic [NUM_LK-1:0]         lk_busy
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_next;
   logic [DEPTH-1:0]  clr_mask;
   logic [DEPTH-1:0]  mark_mask;
   logic [ADDR_W-1:0] clr_addr_a [NUM_CLR];
   logic [ADDR_W-1:0] lk_addr_a  [NUM_LK];

   // Split the packed address buses into per-port fields
   always_comb begin
      for (int k = 0; k < NUM_CLR; k++) begin
         clr_addr_a[k] = clr_addr[field_lo(k, ADDR_W) +: ADDR_W];
      end
      for (int j = 0; j < NUM_LK; j++) begin
         lk_addr_a[j] = lk_addr[field_lo(j, ADDR_W) +: ADDR_W];
      end
   end

   // Clear from writes, then set from the mark so a new producer overrides a retiring one
   always_comb begin
      clr_mask  = '0;
      mark_mask = '0;
      for (int k = 0; k < NUM_CLR; k++) begin
         if (clr_en[k] && clr_addr_a[k] != ZERO_ADDR) begin
            clr_mask[clr_addr_a[k]] = 1'b1;
         end
      end
      if (mark_en && mark_addr != ZERO_ADDR) begin
         mark_mask[mark_addr] = 1'b1;
      end
      busy_next           = (busy & ~clr_mask) | mark_mask;
      busy_next[ZERO_REG] = 1'b0;
   end

   // Busy array register; reset drops every pending producer
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

   // Lookup per read port; with forwarding, a register being written shows its post-edge bit
   always_comb begin
      lk_busy = '0;
      for (int j = 0; j < NUM_LK; j++) begin
`ifdef REGFILE_BYPASS_EN
         if (!rst && clr_mask[lk_addr_a[j]]) begin
            lk_busy[j] = busy_next[lk_addr_a[j]];
         end else begin
            lk_busy[j] = busy[lk_addr_a[j]];
         end
`else
         lk_busy[j] = busy[lk_addr_a[j]];
`endif
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with zero register and busy scoreboard; optional macro REGFILE_BYPASS_EN
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2
)(
   input logic         clk,
   input logic         rst,
   regfile_mp_if.slave bus
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

   logic [DATA_W-1:0]        regs      [DEPTH];
   logic [ADDR_W-1:0]        wr_addr_a [NUM_WR];
   logic [DATA_W-1:0]        wr_data_a [NUM_WR];
   logic [ADDR_W-1:0]        rd_addr_a [NUM_RD];
   logic [NUM_RD*DATA_W-1:0] rd_data_c;

   // Split the packed port buses into per-port fields
   always_comb begin
      for (int k = 0; k < NUM_WR; k++) begin
         wr_addr_a[k] = bus.wr_addr[field_lo(k, ADDR_W) +: ADDR_W];
         wr_data_a[k] = bus.wr_data[field_lo(k, DATA_W) +: DATA_W];
      end
      for (int j = 0; j < NUM_RD; j++) begin
         rd_addr_a[j] = bus.rd_addr[field_lo(j, ADDR_W) +: ADDR_W];
      end
   end

   // Data array; ports applied in ascending order so the highest-index port lands last
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_WR; k++) begin
            if (bus.wr_en[k] && wr_addr_a[k] != ZERO_ADDR) begin
               regs[wr_addr_a[k]] <= wr_data_a[k];
            end
         end
      end
   end

`ifdef REGFILE_BYPASS_EN
   logic [NUM_RD-1:0] fwd_hit;
   logic [DATA_W-1:0] fwd_data [NUM_RD];

   // Same-cycle forwarding: the last matching write port (highest index) supplies the data
   always_comb begin
      fwd_hit = '0;
      for (int j = 0; j < NUM_RD; j++) begin
         fwd_data[j] = '0;
         for (int k = 0; k < NUM_WR; k++) begin
            if (!rst && bus.wr_en[k] && wr_addr_a[k] == rd_addr_a[j] &&
                rd_addr_a[j] != ZERO_ADDR) begin
               fwd_hit[j]  = 1'b1;
               fwd_data[j] = wr_data_a[k];
            end
         end
      end
   end
`endif

   // Combinational read mux; register 0 is forced to zero rather than stored
   always_comb begin
      rd_data_c = '0;
      for (int j = 0; j < NUM_RD; j++) begin
         if (rd_addr_a[j] != ZERO_ADDR) begin
            rd_data_c[field_lo(j, DATA_W) +: DATA_W] = regs[rd_addr_a[j]];
         end
`ifdef REGFILE_BYPASS_EN
         if (fwd_hit[j]) begin
            rd_data_c[field_lo(j, DATA_W) +: DATA_W] = fwd_data[j];
         end
`endif
      end
   end

   assign bus.rd_data = rd_data_c;

   regfile_scoreboard #(
      .ADDR_W  (ADDR_W),
      .NUM_CLR (NUM_WR),
      .NUM_LK  (NUM_RD)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .clr_en    (bus.wr_en),
      .clr_addr  (bus.wr_addr),
      .mark_en   (bus.mark_en),
      .mark_addr (bus.mark_addr),
      .lk_addr   (bus.rd_addr),
      .lk_busy   (bus.rd_busy)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp (default and 16x8/3R/1W builds); honours REGFILE_BYPASS_EN
module tb_regfile_mp;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) bus_a ();
   regfile_mp_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3), .NUM_WR(1)) bus_b ();

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) dut_a (
      .clk (clk), .rst (rst), .bus (bus_a.slave));
   regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3), .NUM_WR(1)) dut_b (
      .clk (clk), .rst (rst), .bus (bus_b.slave));

   typedef struct {
      logic [63:0] rd_data;
      logic [1:0]  rd_busy;
      string       name;
   } exp_a_t;

   typedef struct {
      logic [47:0] rd_data;
      logic [2:0]  rd_busy;
      string       name;
   } exp_b_t;

   exp_a_t q_a[$];
   exp_b_t q_b[$];
   int checks   = 0;
   int failures = 0;
   bit chk_on   = 1'b0;

   // stimulus for the next cycle
   logic        s_rst;
   logic [1:0]  a_en;
   logic [4:0]  a_wa [2];
   logic [31:0] a_wd [2];
   logic        a_mk;
   logic [4:0]  a_ma;
   logic [4:0]  a_ra [2];
   logic        b_en;
   logic [2:0]  b_wa;
   logic [15:0] b_wd;
   logic        b_mk;
   logic [2:0]  b_ma;
   logic [2:0]  b_ra [3];

   // reference state: what each architectural register and busy bit holds
   logic [31:0] m_a_regs [32];
   bit          m_a_busy [32];
   logic [15:0] m_b_regs [8];
   bit          m_b_busy [8];

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin m_a_regs[i] = 32'h0; m_a_busy[i] = 1'b0; end
      for (int i = 0; i < 8; i++)  begin m_b_regs[i] = 16'h0; m_b_busy[i] = 1'b0; end
   endtask

   task automatic idle();
      s_rst = 1'b0;
      a_en = 2'b00; a_mk = 1'b0; a_ma = 5'd0;
      b_en = 1'b0;  b_mk = 1'b0; b_ma = 3'd0; b_wa = 3'd0; b_wd = 16'h0;
      for (int k = 0; k < 2; k++) begin a_wa[k] = 5'd0; a_wd[k] = 32'h0; a_ra[k] = 5'd0; end
      for (int j = 0; j < 3; j++) b_ra[j] = 3'($urandom_range(0, 7));
   endtask

   // Apply stimulus, queue the expected combinational outputs, then advance the model across the edge
   task automatic step(input string name);
      exp_a_t ea;
      exp_b_t eb;
      logic [31:0] d;
      logic [15:0] db;
      bit bz, hit;
      rst = s_rst;
      bus_a.wr_en     = a_en;
      bus_a.wr_addr   = {a_wa[1], a_wa[0]};
      bus_a.wr_data   = {a_wd[1], a_wd[0]};
      bus_a.rd_addr   = {a_ra[1], a_ra[0]};
      bus_a.mark_en   = a_mk;
      bus_a.mark_addr = a_ma;
      bus_b.wr_en     = b_en;
      bus_b.wr_addr   = b_wa;
      bus_b.wr_data   = b_wd;
      bus_b.rd_addr   = {b_ra[2], b_ra[1], b_ra[0]};
      bus_b.mark_en   = b_mk;
      bus_b.mark_addr = b_ma;
      if (chk_on) begin
         ea.name = name;
         for (int j = 0; j < 2; j++) begin
            d = (a_ra[j] == 0) ? 32'h0 : m_a_regs[a_ra[j]];
            bz = m_a_busy[a_ra[j]];
`ifdef REGFILE_BYPASS_EN
            hit = 1'b0;
            for (int k = 0; k < 2; k++)
               if (!s_rst && a_en[k] && a_wa[k] == a_ra[j] && a_ra[j] != 0) begin
                  hit = 1'b1; d = a_wd[k];
               end
            if (hit) bz = a_mk && a_ma == a_ra[j];
`endif
            ea.rd_data[j*32 +: 32] = d;
            ea.rd_busy[j] = bz;
         end
         q_a.push_back(ea);
         eb.name = {name, "/b"};
         for (int j = 0; j < 3; j++) begin
            db = (b_ra[j] == 0) ? 16'h0 : m_b_regs[b_ra[j]];
            bz = m_b_busy[b_ra[j]];
`ifdef REGFILE_BYPASS_EN
            hit = !s_rst && b_en && b_wa == b_ra[j] && b_ra[j] != 0;
            if (hit) begin db = b_wd; bz = b_mk && b_ma == b_ra[j]; end
`endif
            eb.rd_data[j*16 +: 16] = db;
            eb.rd_busy[j] = bz;
         end
         q_b.push_back(eb);
      end
      @(posedge clk);
      if (s_rst) begin
         model_reset();
      end else begin
         for (int k = 0; k < 2; k++)
            if (a_en[k] && a_wa[k] != 0) begin m_a_regs[a_wa[k]] = a_wd[k]; m_a_busy[a_wa[k]] = 1'b0; end
         if (a_mk && a_ma != 0) m_a_busy[a_ma] = 1'b1;
         if (b_en && b_wa != 0) begin m_b_regs[b_wa] = b_wd; m_b_busy[b_wa] = 1'b0; end
         if (b_mk && b_ma != 0) m_b_busy[b_ma] = 1'b1;
      end
      #1;
   endtask

   // Monitor: compares whatever the outputs show mid-cycle against the oldest queued expectation
   always @(negedge clk) begin
      if (q_a.size() > 0) begin
         exp_a_t e;
         e = q_a.pop_front();
         checks += 2;
         if (bus_a.rd_data !== e.rd_data) begin
            failures++;
            $display("FAIL %s rd_data got=%h exp=%h", e.name, bus_a.rd_data, e.rd_data);
         end
         if (bus_a.rd_busy !== e.rd_busy) begin
            failures++;
            $display("FAIL %s rd_busy got=%b exp=%b", e.name, bus_a.rd_busy, e.rd_busy);
         end
      end
      if (q_b.size() > 0) begin
         exp_b_t e;
         e = q_b.pop_front();
         checks += 2;
         if (bus_b.rd_data !== e.rd_data) begin
            failures++;
            $display("FAIL %s rd_data got=%h exp=%h", e.name, bus_b.rd_data, e.rd_data);
         end
         if (bus_b.rd_busy !== e.rd_busy) begin
            failures++;
            $display("FAIL %s rd_busy got=%b exp=%b", e.name, bus_b.rd_busy, e.rd_busy);
         end
      end
   end

   initial begin
      idle();
      s_rst = 1'b1;
      step("init_rst");
      step("init_rst");
      model_reset();
      chk_on = 1'b1;

      idle(); a_ra[0] = 5'd5; a_ra[1] = 5'd31; step("after_reset");

      // reset clears a written register
      idle(); a_en = 2'b01; a_wa[0] = 5'd5; a_wd[0] = 32'hDEADBEEF; a_mk = 1'b1; a_ma = 5'd5; step("wr_r5");
      idle(); a_ra[0] = 5'd5; a_ra[1] = 5'd5; step("r5_written");
      idle(); s_rst = 1'b1; a_en = 2'b11; a_wa[0] = 5'd5; a_wd[0] = 32'h1; a_wa[1] = 5'd6; a_wd[1] = 32'h2;
      a_mk = 1'b1; a_ma = 5'd6; a_ra[0] = 5'd5; a_ra[1] = 5'd6; step("rst_pulse");
      idle(); a_ra[0] = 5'd5; a_ra[1] = 5'd6; step("r5_after_rst");

      // zero register
      idle(); a_en = 2'b01; a_wa[0] = 5'd0; a_wd[0] = 32'h12345678; a_mk = 1'b1; a_ma = 5'd0; step("wr_r0");
      idle(); step("r0_zero");

      // write conflicts
      idle(); a_en = 2'b11; a_wa[0] = 5'd7; a_wd[0] = 32'h11; a_wa[1] = 5'd7; a_wd[1] = 32'h22;
      a_ra[0] = 5'd7; a_ra[1] = 5'd7; step("conflict_r7");
      idle(); a_ra[0] = 5'd7; a_ra[1] = 5'd7; step("r7_port1_wins");
      idle(); a_en = 2'b11; a_wa[0] = 5'd3; a_wd[0] = 32'hAA; a_wa[1] = 5'd4; a_wd[1] = 32'hBB; step("wr_r3_r4");
      idle(); a_ra[0] = 5'd3; a_ra[1] = 5'd4; step("r3_r4");

      // scoreboard
      idle(); a_mk = 1'b1; a_ma = 5'd9; a_ra[0] = 5'd9; step("mark_r9");
      idle(); a_ra[0] = 5'd9; step("r9_busy");
      idle(); a_en = 2'b01; a_wa[0] = 5'd9; a_wd[0] = 32'h99; a_mk = 1'b1; a_ma = 5'd9; a_ra[0] = 5'd9; step("wr_mark_r9");
      idle(); a_ra[0] = 5'd9; step("r9_still_busy");
      idle(); a_en = 2'b10; a_wa[1] = 5'd9; a_wd[1] = 32'h9A; a_ra[0] = 5'd9; a_ra[1] = 5'd9; step("wr_r9");
      idle(); a_ra[0] = 5'd9; a_ra[1] = 5'd9; step("r9_clear");

      // same-cycle read of a register being written
      idle(); a_en = 2'b01; a_wa[0] = 5'd2; a_wd[0] = 32'h55; a_ra[0] = 5'd2; a_ra[1] = 5'd2; step("bypass_r2");
      idle(); a_ra[0] = 5'd2; a_ra[1] = 5'd2; step("r2_next");

      // narrow build sweep: r1..r7 hold addr*0x101
      for (int a = 1; a < 8; a++) begin
         idle(); b_en = 1'b1; b_wa = 3'(a); b_wd = 16'(a * 16'h0101);
         for (int j = 0; j < 3; j++) b_ra[j] = 3'(a);
         step("sweep_wr");
         idle();
         for (int j = 0; j < 3; j++) b_ra[j] = 3'(a);
         step("sweep_rd");
      end

      // randomized traffic, biased to a few addresses so conflicts and busy hazards occur
      for (int n = 0; n < 400; n++) begin
         idle();
         s_rst = ($urandom_range(0, 49) == 0);
         a_en  = 2'($urandom);
         for (int k = 0; k < 2; k++) begin
            a_wa[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            a_wd[k] = $urandom;
            a_ra[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         end
         a_mk = 1'($urandom);
         a_ma = 5'($urandom_range(0, 7));
         b_en = 1'($urandom);
         b_wa = 3'($urandom);
         b_wd = 16'($urandom);
         b_mk = 1'($urandom);
         b_ma = 3'($urandom);
         step("random");
      end

      chk_on = 1'b0;
      idle();
      step("drain");
      step("drain");
      checks++;
      if (q_a.size() + q_b.size() != 0) begin
         failures++;
         $display("FAIL drain pending got=%0d exp=0", q_a.size() + q_b.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
